// File: rtl/sequenciador_palavra_if.sv
// Bus between the word sequencer and its environment (switches/buttons on one
// side, note-word classifier and display logic on the other).
//   master : drives switch notes, buttons and classifier responses (bench/top)
//   slave  : the sequencer itself
interface sequenciador_palavra_if;
  logic [3:0] nota_in;     // {tom,a,b,c} from switches
  logic       enviar;      // capture button, level
  logic       abortar;     // cancel current word, level
  logic [3:0] nota_out;    // note presented to classifier
  logic       nota_valid;  // one-cycle strobe
  logic       fim_in;      // classifier end-of-word flag
  logic [1:0] tipo_in;     // classifier word type
  logic [1:0] tipo_out;    // latched type of last completed word
  logic       palavra_ok;  // pulse when tipo_out updates
  logic       ocupado;     // busy (not collecting)
  logic [3:0] contagem;    // notes currently stored
  logic       erro_cheio;  // sticky overflow
  logic       erro_tempo;  // sticky classifier timeout

  modport master (
    output nota_in, enviar, abortar, fim_in, tipo_in,
    input  nota_out, nota_valid, tipo_out, palavra_ok, ocupado, contagem,
           erro_cheio, erro_tempo
  );

  modport slave (
    input  nota_in, enviar, abortar, fim_in, tipo_in,
    output nota_out, nota_valid, tipo_out, palavra_ok, ocupado, contagem,
           erro_cheio, erro_tempo
  );
endinterface

// File: rtl/sequenciador_palavra.sv
// Word sequencer: collects notes one button press at a time, and when the
// terminator (a,b,c == 000) arrives replays the whole word to the classifier,
// one note every GAP+1 cycles, then waits for the classifier's end flag and
// latches the word type.
// Ports:
//   clk   : clock, everything on posedge
//   Reset : synchronous, active-high
//   sp    : sequenciador_palavra_if.slave (notes, buttons, classifier, status)
module sequenciador_palavra #(
  parameter int DEPTH   = 8,   // entries including terminator (2..16)
  parameter int GAP     = 2,   // idle cycles after each issued note (1..7)
  parameter int TIMEOUT = 64   // max cycles waiting for fim_in (>=4)
) (
  input  logic                  clk,
  input  logic                  Reset,
  sequenciador_palavra_if.slave sp
);

  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {COLETA, EMITE, PAUSA, ESPERA} estado_t;

  estado_t       estado, prox;
  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [2:0]    gap_cnt;
  logic [TW-1:0] t_cnt;
  logic [3:0]    contagem;
  logic [3:0]    nota_out;
  logic          nota_valid, palavra_ok, erro_cheio, erro_tempo, enviar_q;
  logic [1:0]    tipo_out;

  logic press, term_in, cur_term, gap_done, t_done, drop, wr_en;

  always_comb begin
    press    = sp.enviar & ~enviar_q;
    term_in  = (sp.nota_in[2:0] == 3'b000);
    cur_term = (mem[rd_ptr][2:0] == 3'b000);
    gap_done = (gap_cnt == 3'(GAP - 1));
    t_done   = (t_cnt == TW'(TIMEOUT - 1));
    // A letter is refused when storing it would leave the buffer with only
    // the terminator slot plus nothing to spare (count would reach DEPTH-1).
    drop     = ~term_in & (contagem == 4'(DEPTH - 2));
    wr_en    = (estado == COLETA) & ~sp.abortar & press & ~drop;
  end

  // Next-state logic; abortar overrides everything else.
  always_comb begin
    prox = estado;
    if (sp.abortar) prox = COLETA;
    else begin
      case (estado)
        COLETA: if (press && term_in) prox = EMITE;
        EMITE:  prox = PAUSA;
        PAUSA:  if (gap_done) prox = cur_term ? ESPERA : EMITE;
        ESPERA: if (sp.fim_in || t_done) prox = COLETA;
        default: prox = COLETA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) estado <= COLETA;
    else       estado <= prox;
  end

  // Buffer storage needs no reset: contagem/rd_ptr define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[contagem[PW-1:0]] <= sp.nota_in;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      enviar_q   <= 1'b0;
      rd_ptr     <= '0;
      gap_cnt    <= '0;
      t_cnt      <= '0;
      contagem   <= '0;
      nota_out   <= '0;
      nota_valid <= 1'b0;
      palavra_ok <= 1'b0;
      tipo_out   <= '0;
      erro_cheio <= 1'b0;
      erro_tempo <= 1'b0;
    end else begin
      enviar_q   <= sp.enviar;
      nota_valid <= 1'b0;
      palavra_ok <= 1'b0;
      if (sp.abortar) begin
        contagem <= '0;
        rd_ptr   <= '0;
        gap_cnt  <= '0;
        t_cnt    <= '0;
      end else begin
        case (estado)
          COLETA: if (press) begin
            erro_cheio <= 1'b0;
            erro_tempo <= 1'b0;
            if (drop) begin
              contagem   <= '0;
              erro_cheio <= 1'b1;
            end else begin
              contagem <= contagem + 4'd1;
              rd_ptr   <= '0;
            end
          end
          EMITE: begin
            nota_out   <= mem[rd_ptr];
            nota_valid <= 1'b1;
            gap_cnt    <= '0;
          end
          PAUSA: begin
            if (gap_done) begin
              if (cur_term) t_cnt  <= '0;
              else          rd_ptr <= rd_ptr + 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 3'd1;
            end
          end
          ESPERA: begin
            if (sp.fim_in) begin
              tipo_out   <= sp.tipo_in;
              palavra_ok <= 1'b1;
              contagem   <= '0;
              rd_ptr     <= '0;
            end else if (t_done) begin
              erro_tempo <= 1'b1;
              contagem   <= '0;
              rd_ptr     <= '0;
            end else begin
              t_cnt <= t_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sp.nota_out   = nota_out;
  assign sp.nota_valid = nota_valid;
  assign sp.tipo_out   = tipo_out;
  assign sp.palavra_ok = palavra_ok;
  assign sp.ocupado    = (estado != COLETA);
  assign sp.contagem   = contagem;
  assign sp.erro_cheio = erro_cheio;
  assign sp.erro_tempo = erro_tempo;

endmodule

// File: tb/tb_sequenciador_palavra.sv
module tb_sequenciador_palavra;
  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  sequenciador_palavra_if sp();
  sequenciador_palavra #(.DEPTH(8), .GAP(2), .TIMEOUT(64)) dut (
    .clk(clk), .Reset(Reset), .sp(sp)
  );

  // inputs + expected observable outputs for one cycle
  typedef struct packed {
    logic [3:0] nota;
    logic       en, ab, fim;
    logic [1:0] tipo;
    logic [14:0] exp;
  } vec_t;

  int n_chk = 0, n_fail = 0;

  // {valid, nota_out, ocupado, contagem, palavra_ok, tipo_out, erro_cheio, erro_tempo}
  function automatic logic [14:0] pk(logic v, logic [3:0] no, logic oc, logic [3:0] c,
                                     logic ok, logic [1:0] t, logic ec, logic et);
    return {v, no, oc, c, ok, t, ec, et};
  endfunction

  function automatic logic [14:0] outs();
    return pk(sp.nota_valid, sp.nota_out, sp.ocupado, sp.contagem, sp.palavra_ok,
              sp.tipo_out, sp.erro_cheio, sp.erro_tempo);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [3:0] n);
    sp.nota_in = n; sp.enviar = 1'b1; tick();
    sp.enviar = 1'b0; tick();
  endtask

  task automatic abort1();
    sp.abortar = 1'b1; tick(); sp.abortar = 1'b0;
  endtask

  vec_t tbl[16];
  int   nv, nok;

  initial begin
    sp.nota_in = '0; sp.enviar = 0; sp.abortar = 0; sp.fim_in = 0; sp.tipo_in = '0;
    Reset = 1'b1; tick(); tick(); Reset = 1'b0;
    chk("reset_state", 32'(outs()), 32'(pk(0,4'h0,0,4'd0,0,2'b00,0,0)));

    // 1: word 0011,0100,0000 replayed with 3-cycle spacing, then fim_in
    tbl[0]  = '{4'h3,1,0,0,2'b00, pk(0,4'h0,0,4'd1,0,2'b00,0,0)};
    tbl[1]  = '{4'h3,0,0,0,2'b00, pk(0,4'h0,0,4'd1,0,2'b00,0,0)};
    tbl[2]  = '{4'h4,1,0,0,2'b00, pk(0,4'h0,0,4'd2,0,2'b00,0,0)};
    tbl[3]  = '{4'h4,0,0,0,2'b00, pk(0,4'h0,0,4'd2,0,2'b00,0,0)};
    tbl[4]  = '{4'h0,1,0,0,2'b00, pk(0,4'h0,1,4'd3,0,2'b00,0,0)};
    tbl[5]  = '{4'h0,0,0,0,2'b00, pk(1,4'h3,1,4'd3,0,2'b00,0,0)};
    tbl[6]  = '{4'h0,0,0,0,2'b00, pk(0,4'h3,1,4'd3,0,2'b00,0,0)};
    tbl[7]  = '{4'h0,0,0,0,2'b00, pk(0,4'h3,1,4'd3,0,2'b00,0,0)};
    tbl[8]  = '{4'h0,0,0,0,2'b00, pk(1,4'h4,1,4'd3,0,2'b00,0,0)};
    tbl[9]  = '{4'h0,0,0,0,2'b00, pk(0,4'h4,1,4'd3,0,2'b00,0,0)};
    tbl[10] = '{4'h0,0,0,0,2'b00, pk(0,4'h4,1,4'd3,0,2'b00,0,0)};
    tbl[11] = '{4'h0,0,0,0,2'b00, pk(1,4'h0,1,4'd3,0,2'b00,0,0)};
    tbl[12] = '{4'h0,0,0,0,2'b00, pk(0,4'h0,1,4'd3,0,2'b00,0,0)};
    tbl[13] = '{4'h0,0,0,0,2'b00, pk(0,4'h0,1,4'd3,0,2'b00,0,0)};
    tbl[14] = '{4'h0,0,0,1,2'b11, pk(0,4'h0,0,4'd0,1,2'b11,0,0)};
    tbl[15] = '{4'h0,0,0,0,2'b00, pk(0,4'h0,0,4'd0,0,2'b11,0,0)};
    for (int i = 0; i < 16; i++) begin
      sp.nota_in = tbl[i].nota; sp.enviar = tbl[i].en; sp.abortar = tbl[i].ab;
      sp.fim_in = tbl[i].fim; sp.tipo_in = tbl[i].tipo;
      tick();
      chk($sformatf("word_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    sp.fim_in = 0; sp.tipo_in = '0;

    // 2: held button captures once
    sp.nota_in = 4'h5; sp.enviar = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    sp.enviar = 1'b0; tick();
    chk("held_one_capture", 32'(sp.contagem), 32'd1);
    chk("held_not_busy", 32'(sp.ocupado), 32'd0);
    abort1();
    chk("abort_clears", 32'(sp.contagem), 32'd0);

    // 3: overflow on the 7th letter
    for (int i = 1; i <= 6; i++) press(4'(i));
    chk("six_letters", 32'(sp.contagem), 32'd6);
    press(4'h7);
    chk("overflow_cnt", 32'(sp.contagem), 32'd0);
    chk("overflow_flag", 32'(sp.erro_cheio), 32'd1);
    press(4'h4);
    chk("overflow_clear", 32'({sp.erro_cheio, sp.contagem}), 32'({1'b0, 4'd1}));
    abort1();

    // 4: classifier never answers -> timeout after 64 cycles in ESPERA
    press(4'h4);
    sp.nota_in = 4'h0; sp.enviar = 1'b1; tick(); sp.enviar = 1'b0;
    nv = 0;
    for (int i = 0; i < 69; i++) begin tick(); if (sp.nota_valid) nv++; end
    chk("to_still_busy", 32'({sp.ocupado, sp.erro_tempo}), 32'({1'b1, 1'b0}));
    tick();
    chk("to_state", 32'(outs()), 32'(pk(0,4'h0,0,4'd0,0,2'b11,0,1)));
    chk("to_two_notes", 32'(nv), 32'd2);
    press(4'h1);
    chk("to_clear", 32'({sp.erro_tempo, sp.contagem}), 32'({1'b0, 4'd1}));
    abort1();

    // 5: abort during PAUSA of 2nd note with fim_in in the same cycle
    press(4'h3); press(4'h6);
    sp.nota_in = 4'h0; sp.enviar = 1'b1; tick(); sp.enviar = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("ab_second_note", 32'({sp.nota_valid, sp.nota_out}), 32'({1'b1, 4'h6}));
    sp.abortar = 1'b1; sp.fim_in = 1'b1; sp.tipo_in = 2'b01; tick();
    sp.abortar = 1'b0; sp.fim_in = 1'b0;
    chk("ab_state", 32'(outs()), 32'(pk(0,4'h6,0,4'd0,0,2'b11,0,0)));
    nv = 0; nok = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); if (sp.nota_valid) nv++; if (sp.palavra_ok) nok++;
    end
    chk("ab_quiet", 32'({nv[7:0], nok[7:0]}), 32'd0);

    // 7: lone terminator (tom set), fim_in before ESPERA is ignored
    sp.nota_in = 4'h8; sp.enviar = 1'b1; tick(); sp.enviar = 1'b0;
    sp.fim_in = 1'b1; sp.tipo_in = 2'b10;
    tick();
    chk("lone_term_note", 32'({sp.nota_valid, sp.nota_out, sp.contagem}), 32'({1'b1, 4'h8, 4'd1}));
    tick();
    sp.fim_in = 1'b0; tick();
    chk("early_fim_ignored", 32'({sp.ocupado, sp.palavra_ok, sp.tipo_out}), 32'({1'b1, 1'b0, 2'b11}));
    sp.fim_in = 1'b1; tick(); sp.fim_in = 1'b0;
    chk("lone_term_done", 32'(outs()), 32'(pk(0,4'h8,0,4'd0,1,2'b10,0,0)));

    // 6: reset mid-EMITE
    press(4'h5);
    sp.nota_in = 4'h0; sp.enviar = 1'b1; tick(); sp.enviar = 1'b0;
    chk("pre_reset_busy", 32'(sp.ocupado), 32'd1);
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk("reset_mid_emite", 32'(outs()), 32'(pk(0,4'h0,0,4'd0,0,2'b00,0,0)));
    tick();
    chk("post_reset_idle", 32'({sp.nota_valid, sp.ocupado}), 32'd0);
    press(4'h2);
    chk("post_reset_press", 32'(sp.contagem), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
